// File: rtl/oc_led_pkg.sv
// Shared types for the oc_led LED controller and its timebase.
package oc_led_pkg;

  localparam int unsigned LedModeWidth  = 2;
  localparam int unsigned LedIndexWidth = 5;

  typedef enum logic [LedModeWidth-1:0] {
    LedModeOff     = 2'd0,
    LedModeOn      = 2'd1,
    LedModeBlink   = 2'd2,
    LedModeBreathe = 2'd3
  } LedMode;

endpackage

// File: rtl/oc_led_timebase.sv
// Shared PWM/blink/breathe timebase for all LED channels.
// Breathe ramp is present only when OC_LED_CTRL_BREATHE_EN is defined.
module oc_led_timebase #(
  parameter int unsigned PwmBits    = 8,
  parameter int unsigned PwmDivide  = 16,
  parameter int unsigned BlinkWraps = 64
) (
  input  logic               clock,
  input  logic               reset,
  output logic [PwmBits-1:0] pwm_count,
  output logic               pwm_wrap_c,
`ifdef OC_LED_CTRL_BREATHE_EN
  output logic [PwmBits-1:0] ramp,
`endif
  output logic               blink_phase
);

  localparam int unsigned PreWidth   = $clog2(PwmDivide);
  localparam int unsigned BlinkWidth = (BlinkWraps > 1) ? $clog2(BlinkWraps) : 1;
  localparam logic [PreWidth-1:0]   PreLast   = PreWidth'(PwmDivide - 1);
  localparam logic [BlinkWidth-1:0] BlinkLast = BlinkWidth'(BlinkWraps - 1);
  localparam logic [PwmBits-1:0]    PwmMax    = '1;

  logic [PreWidth-1:0]   pre;
  logic [BlinkWidth-1:0] blink_count;
  logic                  pwm_tick;

  assign pwm_tick   = (pre == PreLast);
  assign pwm_wrap_c = pwm_tick && (pwm_count == PwmMax);

  // Prescaler, PWM counter and blink phase
  always_ff @(posedge clock) begin
    if (reset) begin
      pre         <= '0;
      pwm_count   <= '0;
      blink_count <= '0;
      blink_phase <= 1'b0;
    end else begin
      pre <= pwm_tick ? '0 : pre + PreWidth'(1);
      if (pwm_tick) pwm_count <= pwm_count + PwmBits'(1);
      if (pwm_wrap_c) begin
        if (blink_count == BlinkLast) begin
          blink_count <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_count <= blink_count + BlinkWidth'(1);
        end
      end
    end
  end

`ifdef OC_LED_CTRL_BREATHE_EN
  typedef enum logic {RampUp, RampDown} ramp_dir_e;

  ramp_dir_e           dir_q, dir_d;
  logic [PwmBits-1:0]  ramp_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      dir_q <= RampUp;
      ramp  <= '0;
    end else begin
      dir_q <= dir_d;
      ramp  <= ramp_d;
    end
  end

  // Triangle: direction flips on the wrap that lands on an endpoint
  always_comb begin
    dir_d  = dir_q;
    ramp_d = ramp;
    if (pwm_wrap_c) begin
      case (dir_q)
        RampUp: begin
          ramp_d = ramp + PwmBits'(1);
          if (ramp == PwmMax - PwmBits'(1)) dir_d = RampDown;
        end
        RampDown: begin
          ramp_d = ramp - PwmBits'(1);
          if (ramp == PwmBits'(1)) dir_d = RampUp;
        end
        default: dir_d = RampUp;
      endcase
    end
  end
`endif

endmodule

// File: rtl/oc_led_ctrl.sv
// Multi-channel status LED controller: off/on/blink/breathe with PWM brightness.
// Define OC_LED_CTRL_BREATHE_EN for breathe mode; otherwise mode 3 acts as on.
module oc_led_ctrl
  import oc_led_pkg::*;
#(
  parameter int unsigned LedCount   = 3,
  parameter int unsigned PwmBits    = 8,
  parameter int unsigned PwmDivide  = 16,
  parameter int unsigned BlinkWraps = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cfgValid,
  output logic                     cfgReady,
  input  logic [LedIndexWidth-1:0] cfgIndex,
  input  logic [LedModeWidth-1:0]  cfgMode,
  input  logic [PwmBits-1:0]       cfgBright,
  output logic                     cfgError,
  output logic [LedCount-1:0]      ledOut
);

  localparam logic [PwmBits-1:0] PwmMax = '1;

  logic [PwmBits-1:0] pwm_count;
  logic               pwm_wrap_c;
  logic               blink_phase;
  logic               cfg_fire_c;
  logic               cfg_in_range_c;
`ifdef OC_LED_CTRL_BREATHE_EN
  logic [PwmBits-1:0] ramp;
`endif

  oc_led_timebase #(
    .PwmBits    (PwmBits),
    .PwmDivide  (PwmDivide),
    .BlinkWraps (BlinkWraps)
  ) u_timebase (
    .clock       (clock),
    .reset       (reset),
    .pwm_count   (pwm_count),
    .pwm_wrap_c  (pwm_wrap_c),
`ifdef OC_LED_CTRL_BREATHE_EN
    .ramp        (ramp),
`endif
    .blink_phase (blink_phase)
  );

  assign cfg_fire_c     = cfgValid && cfgReady;
  assign cfg_in_range_c = (32'(cfgIndex) < LedCount);

  always_ff @(posedge clock) begin
    if (reset) begin
      cfgReady <= 1'b0;
      cfgError <= 1'b0;
    end else begin
      cfgReady <= 1'b1;
      cfgError <= cfg_fire_c && !cfg_in_range_c;
    end
  end

  for (genvar i = 0; i < int'(LedCount); i++) begin : g_ch
    LedMode             shadow_mode, active_mode;
    logic [PwmBits-1:0] shadow_bright, active_bright;
    logic [PwmBits-1:0] duty_c;
    logic               wr_c;
    logic               led_q;
`ifdef OC_LED_CTRL_BREATHE_EN
    logic [2*PwmBits-1:0] prod_c;
`endif

    assign wr_c      = cfg_fire_c && (cfgIndex == LedIndexWidth'(i));
    assign ledOut[i] = led_q;

    // Active settings change only on a PWM wrap so a period is never torn
    always_ff @(posedge clock) begin
      if (reset) begin
        shadow_mode   <= LedModeOff;
        shadow_bright <= '0;
        active_mode   <= LedModeOff;
        active_bright <= '0;
        led_q         <= 1'b0;
      end else begin
        if (wr_c) begin
          shadow_mode   <= LedMode'(cfgMode);
          shadow_bright <= cfgBright;
        end
        if (pwm_wrap_c) begin
          active_mode   <= shadow_mode;
          active_bright <= shadow_bright;
        end
        led_q <= (duty_c == PwmMax) || (pwm_count < duty_c);
      end
    end

    always_comb begin
      duty_c = '0;
`ifdef OC_LED_CTRL_BREATHE_EN
      prod_c = (2*PwmBits)'(ramp) * (2*PwmBits)'(active_bright);
`endif
      case (active_mode)
        LedModeOff:   duty_c = '0;
        LedModeOn:    duty_c = active_bright;
        LedModeBlink: duty_c = blink_phase ? active_bright : '0;
`ifdef OC_LED_CTRL_BREATHE_EN
        LedModeBreathe:
          duty_c = (active_bright == PwmMax) ? ramp : prod_c[2*PwmBits-1:PwmBits];
`else
        LedModeBreathe: duty_c = active_bright;
`endif
        default:      duty_c = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_oc_led_ctrl.sv
// Self-checking bench for oc_led_ctrl: table vectors, corner sequences and random writes.
module tb_oc_led_ctrl;

  localparam int unsigned LedCount   = 3;
  localparam int unsigned PwmBits    = 4;
  localparam int unsigned PwmDivide  = 2;
  localparam int unsigned BlinkWraps = 2;
  localparam int Max    = (1 << PwmBits) - 1;
  localparam int Period = PwmDivide * (1 << PwmBits);

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cfgValid = 1'b0;
  logic       cfgReady;
  logic [4:0] cfgIndex = '0;
  logic [1:0] cfgMode = '0;
  logic [3:0] cfgBright = '0;
  logic       cfgError;
  logic [2:0] ledOut;

  always #5 clock = ~clock;

  oc_led_ctrl #(
    .LedCount   (LedCount),
    .PwmBits    (PwmBits),
    .PwmDivide  (PwmDivide),
    .BlinkWraps (BlinkWraps)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cfgValid  (cfgValid),
    .cfgReady  (cfgReady),
    .cfgIndex  (cfgIndex),
    .cfgMode   (cfgMode),
    .cfgBright (cfgBright),
    .cfgError  (cfgError),
    .ledOut    (ledOut)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: time is a plain cycle count since reset release
  int   mc;
  int   sh_mode[LedCount], sh_br[LedCount], ac_mode[LedCount], ac_br[LedCount];
  logic [2:0] exp_led;
  logic exp_ready, exp_err;

  typedef struct {
    int ch;
    int mode;
    int br;
    int exp_lit;
  } vec_t;

  vec_t tbl[6];

  function automatic int ramp_at(input int p);
    int q;
    q = p % (2 * Max);
    return (q <= Max) ? q : (2 * Max - q);
  endfunction

  function automatic int duty_of(input int mode, input int br, input int p);
    case (mode)
      0: return 0;
      1: return br;
      2: return (((p / BlinkWraps) % 2) == 1) ? br : 0;
`ifdef OC_LED_CTRL_BREATHE_EN
      default: return (br == Max) ? ramp_at(p) : (ramp_at(p) * br) / (Max + 1);
`else
      default: return br;
`endif
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (model cycle %0d)", name, act, exp, mc);
  endtask

  task automatic model_edge();
    int pwm, p, d;
    if (reset) begin
      mc = 0;
      for (int i = 0; i < int'(LedCount); i++) begin
        sh_mode[i] = 0; sh_br[i] = 0; ac_mode[i] = 0; ac_br[i] = 0;
      end
      exp_led = '0; exp_ready = 1'b0; exp_err = 1'b0;
    end else begin
      pwm = (mc / PwmDivide) % (Max + 1);
      p   = mc / Period;
      for (int i = 0; i < int'(LedCount); i++) begin
        d = duty_of(ac_mode[i], ac_br[i], p);
        exp_led[i] = (d == Max) || (pwm < d);
      end
      exp_err = cfgValid && exp_ready && (int'(cfgIndex) >= int'(LedCount));
      if (mc % Period == Period - 1) begin
        for (int i = 0; i < int'(LedCount); i++) begin
          ac_mode[i] = sh_mode[i]; ac_br[i] = sh_br[i];
        end
      end
      if (cfgValid && exp_ready && (int'(cfgIndex) < int'(LedCount))) begin
        sh_mode[cfgIndex] = int'(cfgMode);
        sh_br[cfgIndex]   = int'(cfgBright);
      end
      exp_ready = 1'b1;
      mc++;
    end
  endtask

  task automatic step(input logic v, input int idx, input int mode, input int br, input logic rst);
    reset     = rst;
    cfgValid  = v;
    cfgIndex  = 5'(idx);
    cfgMode   = 2'(mode);
    cfgBright = 4'(br);
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("ledOut", int'(ledOut), int'(exp_led));
    check("cfgReady", int'(cfgReady), int'(exp_ready));
    check("cfgError", int'(cfgError), int'(exp_err));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic align(input int r);
    for (int k = 0; k < Period && (mc % Period) != r; k++) step(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic count_lit(input int ch, input int n, output int lit);
    lit = 0;
    for (int k = 0; k < n; k++) begin
      step(1'b0, 0, 0, 0, 1'b0);
      lit += int'(ledOut[ch]);
    end
  endtask

  task automatic write_cfg(input int ch, input int mode, input int br);
    align(5);
    step(1'b1, ch, mode, br, 1'b0);
    align(0);
  endtask

  initial begin
    int lit;
    tbl[0] = '{0, 1, 8, 16};
    tbl[1] = '{0, 1, 15, 32};
    tbl[2] = '{0, 1, 0, 0};
    tbl[3] = '{0, 1, 3, 6};
    tbl[4] = '{0, 0, 15, 0};
    tbl[5] = '{2, 1, 1, 2};

    @(negedge clock);
    for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 0, 1'b1);
    check("reset_led", int'(ledOut), 0);
    check("reset_ready", int'(cfgReady), 0);
    check("reset_err", int'(cfgError), 0);

    step(1'b0, 0, 0, 0, 1'b0);
    check("ready_rise", int'(cfgReady), 1);
    idle(63);
    check("idle_dark", int'(ledOut), 0);

    // Steady-state lit cycles per PWM period for fixed duties
    for (int t = 0; t < 6; t++) begin
      write_cfg(tbl[t].ch, tbl[t].mode, tbl[t].br);
      count_lit(tbl[t].ch, Period, lit);
      check($sformatf("vec%0d_lit", t), lit, tbl[t].exp_lit);
    end

    write_cfg(1, 2, 15);
    count_lit(1, 2 * BlinkWraps * Period, lit);
    check("blink_lit", lit, BlinkWraps * Period);

    write_cfg(2, 3, 15);
    count_lit(2, 2 * Max * Period, lit);
`ifdef OC_LED_CTRL_BREATHE_EN
    check("breathe_lit", lit, 452);
`else
    check("breathe_lit", lit, 2 * Max * Period);
`endif

    step(1'b1, 5, 1, 15, 1'b0);
    check("err_pulse", int'(cfgError), 1);
    step(1'b0, 0, 0, 0, 1'b0);
    check("err_clear", int'(cfgError), 0);

    // Write presented on the wrap cycle lands one period later
    write_cfg(0, 0, 0);
    align(Period - 1);
    step(1'b1, 0, 1, 15, 1'b0);
    count_lit(0, Period, lit);
    check("wrap_write_old", lit, 0);
    count_lit(0, Period, lit);
    check("wrap_write_new", lit, Period);

    idle(40);
    step(1'b0, 0, 0, 0, 1'b1);
    check("midrst_led", int'(ledOut), 0);
    check("midrst_ready", int'(cfgReady), 0);
    step(1'b0, 0, 0, 0, 1'b0);
    for (int ch = 0; ch < int'(LedCount); ch++) begin
      count_lit(ch, 2 * Period, lit);
      check($sformatf("post_rst_ch%0d", ch), lit, 0);
    end

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0)
        step(1'b1, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 15)), 1'b0);
      else
        step(1'b0, 0, 0, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
